multdiv_iter: RTL and testbench

MULTDIV_ITER -- requirements
Module: multdiv_iter

---
 rtl/multdiv_pkg.sv | 52 +++++
 rtl/multdiv_abs.sv | 12 +
 rtl/multdiv_iter.sv | 156 +++++++++++++++
 tb/tb_multdiv_iter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit:
// operation and FSM state enums, iteration counts and operation decoders.
package multdiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int unsigned mul_cycles(input int unsigned width, input int unsigned mul_bits);
    return width / mul_bits;
  endfunction

  // Radix-2 restoring division retires one quotient bit per cycle.
  function automatic int unsigned div_cycles(input int unsigned width);
    return width;
  endfunction

  function automatic logic is_mul(input op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
  endfunction

  function automatic logic is_rem(input op_e op);
    return (op inside {OP_REM, OP_REMU});
  endfunction

  function automatic logic is_high(input op_e op);
    return (op inside {OP_MULH, OP_MULHSU, OP_MULHU});
  endfunction

  function automatic logic a_signed(input op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  function automatic logic b_signed(input op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  endfunction

endpackage

// File: rtl/multdiv_abs.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module multdiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/multdiv_iter.sv
// Iterative multiplier (MUL_BITS per cycle) / radix-2 restoring divider.
// Define MULTDIV_ITER_EARLY_TERM_EN to finish trivial operations at accept.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(mul_cycles(WIDTH, MUL_BITS) - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(div_cycles(WIDTH) - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             r_state, w_next;
  op_e                r_op;
  logic               r_neg, r_dz;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;  // product (mul) or partial remainder (div)
  logic [2*WIDTH-1:0] r_a;    // shifted multiplicand (mul) or dividend/quotient (div)
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept, w_a_neg, w_b_neg, w_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_pp, w_fix_in, w_fix_out;
  logic [WIDTH:0]     w_shift, w_diff, w_rem_next;
  logic               w_ge;
  logic [WIDTH-1:0]   w_fix_res;
  logic               w_early;
  logic [WIDTH-1:0]   w_early_res;

  // Request is taken on an edge where req_valid_i & req_ready_o; a response is
  // consumed on an edge where resp_valid_o & resp_ready_i. Neither side may
  // withdraw: the unit holds resp_valid_o/result_o until consumed.
  assign w_accept     = req_valid_i & req_ready_o;
  assign req_ready_o  = (r_state == ST_IDLE);
  assign busy_o       = (r_state != ST_IDLE);
  assign resp_valid_o = (r_state == ST_DONE);
  assign result_o     = r_result;

  assign w_a_neg = a_signed(op_i) & op_a_i[WIDTH-1];
  assign w_b_neg = b_signed(op_i) & op_b_i[WIDTH-1];

  multdiv_abs #(.W(WIDTH)) u_abs_a (.i_val(op_a_i), .i_neg(w_a_neg), .o_val(w_mag_a));
  multdiv_abs #(.W(WIDTH)) u_abs_b (.i_val(op_b_i), .i_neg(w_b_neg), .o_val(w_mag_b));

  assign w_pp       = r_a * {{(2*WIDTH-MUL_BITS){1'b0}}, r_b[MUL_BITS-1:0]};
  assign w_shift    = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_rem_next = w_ge ? w_diff : w_shift;

  assign w_fix_in = is_mul(r_op) ? r_acc
                  : {{WIDTH{1'b0}}, (is_rem(r_op) ? r_acc[WIDTH-1:0] : r_a[WIDTH-1:0])};

  multdiv_abs #(.W(2*WIDTH)) u_abs_fix (.i_val(w_fix_in), .i_neg(r_neg), .o_val(w_fix_out));

  // Signed divide by zero would otherwise pick up the sign fix on all-ones.
  always_comb begin
    w_fix_res = w_fix_out[WIDTH-1:0];
    if (is_high(r_op))                 w_fix_res = w_fix_out[2*WIDTH-1:WIDTH];
    else if (r_op == OP_DIV && r_dz)   w_fix_res = '1;
  end

`ifdef MULTDIV_ITER_EARLY_TERM_EN
  always_comb begin
    w_early     = 1'b0;
    w_early_res = '0;
    if (is_mul(op_i)) begin
      w_early = (op_a_i == '0) || (op_b_i == '0);
    end else if (op_b_i == '0) begin
      w_early     = 1'b1;
      w_early_res = is_rem(op_i) ? op_a_i : '1;
    end else if (a_signed(op_i) && op_a_i == MOST_NEG && op_b_i == '1) begin
      w_early     = 1'b1;
      w_early_res = is_rem(op_i) ? '0 : op_a_i;
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  assign w_last = (r_cnt == (is_mul(r_op) ? MUL_LAST : DIV_LAST));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)          w_next = w_early ? ST_DONE : ST_CALC;
      ST_CALC: if (kill_i)            w_next = ST_IDLE;
               else if (w_last)       w_next = ST_FIX;
      ST_FIX:  w_next = kill_i ? ST_IDLE : ST_DONE;
      ST_DONE: if (resp_ready_i)      w_next = ST_IDLE;
      default:                        w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op  <= op_i;
          r_neg <= is_rem(op_i) ? w_a_neg : (w_a_neg ^ w_b_neg);
          r_dz  <= (op_b_i == '0);
          r_cnt <= '0;
          r_acc <= '0;
          r_a   <= {{WIDTH{1'b0}}, w_mag_a};
          r_b   <= w_mag_b;
          if (w_early) r_result <= w_early_res;
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (is_mul(r_op)) begin
            r_acc <= r_acc + w_pp;
            r_a   <= r_a << MUL_BITS;
            r_b   <= r_b >> MUL_BITS;
          end else begin
            r_acc <= {{(WIDTH-1){1'b0}}, w_rem_next};
            r_a   <= {{WIDTH{1'b0}}, r_a[WIDTH-2:0], w_ge};
          end
        end
        ST_FIX: if (!kill_i) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter (WIDTH 32, MUL_BITS 8): driver pushes expected
// result and latency into queues; a negedge monitor pops and compares.
module tb_multdiv_iter;
  import multdiv_pkg::*;

`ifdef MULTDIV_ITER_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int L_MUL = 6;
  localparam int L_DIV = 34;
  localparam int L_MUL_Z = EARLY ? 1 : L_MUL;
  localparam int L_DIV_S = EARLY ? 1 : L_DIV;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  op_e         op_i;
  logic [31:0] op_a_i, op_b_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  multdiv_iter #(.WIDTH(32), .MUL_BITS(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .result_o(result_o), .busy_o(busy_o)
  );

  // clock / cycle counter
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit want_resp);
    int waited = 0;
    @(negedge clk_i);
    while (!req_ready_o && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    check("req_ready_timeout", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    op_i = op; op_a_i = a; op_b_i = b;
    if (want_resp) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    op_a_i = $urandom_range(0, 32'hFFFF);
    op_b_i = $urandom_range(0, 32'hFFFF);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(negedge clk_i);
      waited++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  // scoreboard monitor
  logic        prev_valid = 1'b0;
  logic [31:0] held;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_valid = 1'b0;
    end else begin
      if (resp_valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {31'b0, resp_valid_o}, 32'd0);
        end else begin
          check("result", result_o, exp_q.pop_front());
          check("latency", cyc - acc_q.pop_front(), lat_q.pop_front());
        end
        held = result_o;
      end else if (resp_valid_o && prev_valid) begin
        check("hold_result", result_o, held);
        check("hold_req_ready", {31'b0, req_ready_o}, 32'd0);
      end
      prev_valid = resp_valid_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_ni = 1'b0; req_valid_i = 1'b0; op_i = OP_MUL; op_a_i = '0; op_b_i = '0;
    kill_i = 1'b0; resp_ready_i = 1'b1;
    #1;
    check("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_req_ready", {31'b0, req_ready_o}, 32'd1);

    // multiply
    issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, L_MUL, 1);
    issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, L_MUL, 1);
    issue(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, L_MUL, 1);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, L_MUL, 1);
    issue(OP_MUL,    32'h12345678, 32'h10,       32'h23456780, L_MUL, 1);
    issue(OP_MUL,    32'd0,        32'd5,        32'd0,        L_MUL_Z, 1);
    // divide / remainder
    issue(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, L_DIV, 1);
    issue(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, L_DIV, 1);
    issue(OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, L_DIV, 1);
    issue(OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        L_DIV, 1);
    issue(OP_DIVU,   32'd100,      32'd7,        32'd14,       L_DIV, 1);
    issue(OP_REMU,   32'd100,      32'd7,        32'd2,        L_DIV, 1);
    // divide by zero / signed overflow
    issue(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, L_DIV_S, 1);
    issue(OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, L_DIV_S, 1);
    issue(OP_REM,    32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, L_DIV_S, 1);
    issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, L_DIV_S, 1);
    issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        L_DIV_S, 1);
    drain();

    // kill in CALC cycle 10
    issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 0, 0);
    repeat (9) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    check("kill_busy", {31'b0, busy_o}, 32'd0);
    check("kill_req_ready", {31'b0, req_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("kill_no_resp", {31'b0, resp_valid_o}, 32'd0);
      @(negedge clk_i);
    end
    issue(OP_MUL, 32'd9, 32'd11, 32'd99, L_MUL, 1);
    drain();

    // response back-pressure for 5 cycles
    resp_ready_i = 1'b0;
    issue(OP_MUL, 32'd3, 32'd4, 32'd12, L_MUL, 1);
    waited = 0;
    while (!resp_valid_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    check("stall_resp_seen", {31'b0, resp_valid_o}, 32'd1);
    repeat (5) @(negedge clk_i);
    resp_ready_i = 1'b1;
    drain();

    // reset mid-CALC
    issue(OP_DIVU, 32'd100, 32'd3, 32'd0, 0, 0);
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("midrst_req_ready", {31'b0, req_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_resp", {31'b0, resp_valid_o}, 32'd0);
      @(negedge clk_i);
    end
    issue(OP_DIVU, 32'd100, 32'd3, 32'd33, L_DIV, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
